// File: rtl/r200_mem.sv
// r200 memory-access stage: issues data-memory requests for loads/stores,
// aligns and extends load data, and registers results toward writeback.
module r200_mem (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu_res,
    input  logic [31:0] in_store_data,
    input  logic [2:0]  in_func3,
    input  logic        in_load,
    input  logic        in_store,
    input  logic [4:0]  in_rd,
    input  logic        in_reg_write,
    output logic        dmem_req,
    input  logic        dmem_gnt,
    output logic [31:0] dmem_addr,
    output logic        dmem_we,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_we,
    output logic        wb_fault
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned RW   = 5;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

    state_e            state_q, state_d;
    logic              is_load_q, is_load_d;
    logic [2:0]        func3_q, func3_d;
    logic [1:0]        lane_q, lane_d;
    logic [RW-1:0]     rd_q, rd_d;
    logic              reg_write_q, reg_write_d;

    logic              dmem_req_q, dmem_req_d;
    logic [XLEN-1:0]   dmem_addr_q, dmem_addr_d;
    logic              dmem_we_q, dmem_we_d;
    logic [3:0]        dmem_be_q, dmem_be_d;
    logic [XLEN-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic              wb_valid_q, wb_valid_d;
    logic [RW-1:0]     wb_rd_q, wb_rd_d;
    logic [XLEN-1:0]   wb_data_q, wb_data_d;
    logic              wb_we_q, wb_we_d;
    logic              wb_fault_q, wb_fault_d;

    logic              accept_c;
    logic              f3_legal_c;
    logic              misaligned_c;
    logic              fault_c;
    logic [3:0]        be_c;
    logic [XLEN-1:0]   wdata_c;
    logic [XLEN-1:0]   shifted_c;
    logic [XLEN-1:0]   load_val_c;

    assign in_ready = rst_n & (state_q == IDLE);
    assign accept_c = in_valid & in_ready;

    // Legality, alignment, byte enables and lane-replicated store data at acceptance
    always_comb begin
        f3_legal_c = 1'b0;
        case (in_func3)
            3'b000, 3'b001, 3'b010: f3_legal_c = 1'b1;
            3'b100, 3'b101:         f3_legal_c = ~in_store;
            default:                f3_legal_c = 1'b0;
        endcase
        misaligned_c = ((in_func3[1:0] == 2'b01) && in_alu_res[0]) ||
                       ((in_func3[1:0] == 2'b10) && (in_alu_res[1:0] != 2'b00));
        fault_c = ~f3_legal_c | misaligned_c | (in_load & in_store);
        case (in_func3[1:0])
            2'b00: begin
                be_c    = 4'b0001 << in_alu_res[1:0];
                wdata_c = {4{in_store_data[7:0]}};
            end
            2'b01: begin
                be_c    = in_alu_res[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{in_store_data[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = in_store_data;
            end
        endcase
    end

    // Lane select and sign/zero extension of returned load data
    always_comb begin
        shifted_c = dmem_rdata >> {lane_q, 3'b000};
        case (func3_q)
            3'b000:  load_val_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b100:  load_val_c = {24'd0, shifted_c[7:0]};
            3'b001:  load_val_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b101:  load_val_c = {16'd0, shifted_c[15:0]};
            default: load_val_c = shifted_c;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        is_load_d    = is_load_q;
        func3_d      = func3_q;
        lane_d       = lane_q;
        rd_d         = rd_q;
        reg_write_d  = reg_write_q;
        dmem_req_d   = dmem_req_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_we_d    = dmem_we_q;
        dmem_be_d    = dmem_be_q;
        dmem_wdata_d = dmem_wdata_q;
        wb_valid_d   = 1'b0;
        wb_rd_d      = wb_rd_q;
        wb_data_d    = wb_data_q;
        wb_we_d      = wb_we_q;
        wb_fault_d   = wb_fault_q;

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    is_load_d   = in_load;
                    func3_d     = in_func3;
                    lane_d      = in_alu_res[1:0];
                    rd_d        = in_rd;
                    reg_write_d = in_reg_write;
                    if (!in_load && !in_store) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_data_d  = in_alu_res;
                        wb_we_d    = in_reg_write;
                        wb_fault_d = 1'b0;
                    end else if (fault_c) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = in_rd;
                        wb_we_d    = 1'b0;
                        wb_fault_d = 1'b1;
                    end else begin
                        state_d      = REQ;
                        dmem_req_d   = 1'b1;
                        dmem_addr_d  = {in_alu_res[31:2], 2'b00};
                        dmem_we_d    = in_store;
                        dmem_be_d    = be_c;
                        dmem_wdata_d = wdata_c;
                    end
                end
            end
            REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d = 1'b0;
                    if (is_load_q) begin
                        state_d = RESP;
                    end else begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_we_d    = 1'b0;
                        wb_fault_d = 1'b0;
                    end
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_rd_d    = rd_q;
                    wb_data_d  = load_val_c;
                    wb_we_d    = reg_write_q;
                    wb_fault_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            is_load_q    <= 1'b0;
            func3_q      <= 3'd0;
            lane_q       <= 2'd0;
            rd_q         <= '0;
            reg_write_q  <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_we_q    <= 1'b0;
            dmem_be_q    <= 4'd0;
            dmem_wdata_q <= '0;
            wb_valid_q   <= 1'b0;
            wb_rd_q      <= '0;
            wb_data_q    <= '0;
            wb_we_q      <= 1'b0;
            wb_fault_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            is_load_q    <= is_load_d;
            func3_q      <= func3_d;
            lane_q       <= lane_d;
            rd_q         <= rd_d;
            reg_write_q  <= reg_write_d;
            dmem_req_q   <= dmem_req_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_we_q    <= dmem_we_d;
            dmem_be_q    <= dmem_be_d;
            dmem_wdata_q <= dmem_wdata_d;
            wb_valid_q   <= wb_valid_d;
            wb_rd_q      <= wb_rd_d;
            wb_data_q    <= wb_data_d;
            wb_we_q      <= wb_we_d;
            wb_fault_q   <= wb_fault_d;
        end
    end

    assign dmem_req   = dmem_req_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_be    = dmem_be_q;
    assign dmem_wdata = dmem_wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign wb_we      = wb_we_q;
    assign wb_fault   = wb_fault_q;

endmodule

// File: tb/tb_r200_mem.sv
// Bench for r200_mem: directed vector table, hand-written reset/throughput
// sequences, and random transactions checked against a byte-level model.
module tb_r200_mem;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_alu_res = '0;
    logic [31:0] in_store_data = '0;
    logic [2:0]  in_func3 = '0;
    logic        in_load = 1'b0;
    logic        in_store = 1'b0;
    logic [4:0]  in_rd = '0;
    logic        in_reg_write = 1'b0;
    logic        dmem_req;
    logic        dmem_gnt = 1'b0;
    logic [31:0] dmem_addr;
    logic        dmem_we;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_we;
    logic        wb_fault;

    int unsigned n_chk = 0;
    int unsigned n_fail = 0;

    always #5 clk = ~clk;

    r200_mem dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_alu_res(in_alu_res), .in_store_data(in_store_data),
        .in_func3(in_func3), .in_load(in_load), .in_store(in_store),
        .in_rd(in_rd), .in_reg_write(in_reg_write),
        .dmem_req(dmem_req), .dmem_gnt(dmem_gnt), .dmem_addr(dmem_addr),
        .dmem_we(dmem_we), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .wb_we(wb_we), .wb_fault(wb_fault)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw;
        int unsigned gw;
        int unsigned rvw;
        logic        e_fault;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic [31:0] e_data;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic ld, input logic st, input logic [2:0] f3,
                                input logic [31:0] addr, input logic [31:0] sdata,
                                input logic [31:0] rdata, input logic [4:0] rd, input logic rw,
                                input int unsigned gw, input int unsigned rvw,
                                input logic e_fault, input logic e_we, input logic [3:0] e_be,
                                input logic [31:0] e_wdata, input logic [31:0] e_data);
        vec_t v;
        v.ld = ld; v.st = st; v.f3 = f3; v.addr = addr; v.sdata = sdata; v.rdata = rdata;
        v.rd = rd; v.rw = rw; v.gw = gw; v.rvw = rvw; v.e_fault = e_fault; v.e_we = e_we;
        v.e_be = e_be; v.e_wdata = e_wdata; v.e_data = e_data;
        return v;
    endfunction

    // Reference: access size in bytes, alignment by modulo, extension by arithmetic
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        int unsigned size;
        int unsigned off;
        longint unsigned mask;
        longint unsigned val;
        logic legal;
        size = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
        off  = v.addr % 4;
        legal = (v.f3 == 3'd0 || v.f3 == 3'd1 || v.f3 == 3'd2 ||
                 v.f3 == 3'd4 || v.f3 == 3'd5) && !(v.st && v.f3[2]);
        r.e_be = '0; r.e_wdata = '0; r.e_data = '0;
        if (!v.ld && !v.st) begin
            r.e_fault = 1'b0; r.e_we = v.rw; r.e_data = v.addr;
            return r;
        end
        r.e_fault = (v.ld && v.st) || !legal || (v.addr % size != 0);
        r.e_we = (!r.e_fault && v.ld) ? v.rw : 1'b0;
        mask = (64'd1 << (8 * size)) - 64'd1;
        r.e_be = 4'(((64'd1 << size) - 64'd1) << off);
        if (size == 1)      r.e_wdata = (v.sdata & 32'hFF) * 32'h01010101;
        else if (size == 2) r.e_wdata = (v.sdata & 32'hFFFF) * 32'h00010001;
        else                r.e_wdata = v.sdata;
        val = (64'(v.rdata) >> (8 * off)) & mask;
        if (!v.f3[2] && size < 4 && ((val >> (8 * size - 1)) & 64'd1) == 64'd1)
            val = val | (64'hFFFF_FFFF & ~mask);
        r.e_data = 32'(val);
        return r;
    endfunction

    task automatic drive(input vec_t v);
        in_valid = 1'b1; in_load = v.ld; in_store = v.st; in_func3 = v.f3;
        in_alu_res = v.addr; in_store_data = v.sdata; in_rd = v.rd; in_reg_write = v.rw;
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0;
        in_alu_res = $urandom; in_store_data = $urandom; in_func3 = 3'($urandom);
        in_load = 1'($urandom); in_store = 1'($urandom); in_rd = 5'($urandom);
    endtask

    // One full transaction; entered and left #1 after a rising edge
    task automatic run(input vec_t v, input string nm);
        chk({nm, " in_ready"}, 32'(in_ready), 32'd1);
        drive(v);
        @(posedge clk); #1;
        idle_inputs();
        if (v.e_fault || (!v.ld && !v.st)) begin
            chk({nm, " no_req"}, 32'(dmem_req), 32'd0);
            chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
            chk({nm, " wb_fault"}, 32'(wb_fault), 32'(v.e_fault));
            chk({nm, " wb_we"}, 32'(wb_we), 32'(v.e_we));
            if (!v.e_fault) chk({nm, " wb_data"}, wb_data, v.e_data);
        end else begin
            for (int c = 0; c <= int'(v.gw); c++) begin
                chk({nm, " req"}, 32'(dmem_req), 32'd1);
                chk({nm, " addr"}, dmem_addr, v.addr & 32'hFFFF_FFFC);
                chk({nm, " be"}, 32'(dmem_be), 32'(v.e_be));
                chk({nm, " we"}, 32'(dmem_we), 32'(v.st));
                if (v.st) chk({nm, " wdata"}, dmem_wdata, v.e_wdata);
                chk({nm, " in_ready_busy"}, 32'(in_ready), 32'd0);
                dmem_gnt = (c == int'(v.gw));
                dmem_rvalid = (c != int'(v.gw)) ? 1'($urandom) : 1'b0;
                dmem_rdata = $urandom;
                @(posedge clk); #1;
                dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
                if (c != int'(v.gw)) chk({nm, " wb_quiet"}, 32'(wb_valid), 32'd0);
            end
            chk({nm, " req_drop"}, 32'(dmem_req), 32'd0);
            if (v.st) begin
                chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
                chk({nm, " wb_we"}, 32'(wb_we), 32'd0);
                chk({nm, " wb_fault"}, 32'(wb_fault), 32'd0);
            end else begin
                chk({nm, " wb_wait"}, 32'(wb_valid), 32'd0);
                for (int c = 0; c < int'(v.rvw); c++) begin
                    dmem_gnt = 1'($urandom);
                    @(posedge clk); #1;
                    dmem_gnt = 1'b0;
                    chk({nm, " wb_wait"}, 32'(wb_valid), 32'd0);
                end
                dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
                @(posedge clk); #1;
                dmem_rvalid = 1'b0; dmem_rdata = $urandom;
                chk({nm, " wb_valid"}, 32'(wb_valid), 32'd1);
                chk({nm, " wb_data"}, wb_data, v.e_data);
                chk({nm, " wb_we"}, 32'(wb_we), 32'(v.e_we));
                chk({nm, " wb_fault"}, 32'(wb_fault), 32'd0);
            end
        end
        chk({nm, " wb_rd"}, 32'(wb_rd), 32'(v.rd));
        @(posedge clk); #1;
        chk({nm, " wb_pulse"}, 32'(wb_valid), 32'd0);
    endtask

    vec_t tbl[13];
    vec_t v;

    initial begin
        tbl[0]  = mk(0,1,3'd0,32'h1003,32'h000000A5,0,5'd5,1,2,0, 0,0,4'b1000,32'hA5A5A5A5,0);
        tbl[1]  = mk(1,0,3'd0,32'h2002,0,32'h00800000,5'd6,1,1,2, 0,1,4'b0100,0,32'hFFFFFF80);
        tbl[2]  = mk(1,0,3'd4,32'h2002,0,32'h00800000,5'd7,1,0,1, 0,1,4'b0100,0,32'h00000080);
        tbl[3]  = mk(1,0,3'd1,32'h2002,0,32'h80010000,5'd8,1,0,0, 0,1,4'b1100,0,32'hFFFF8001);
        tbl[4]  = mk(1,0,3'd5,32'h2002,0,32'h80010000,5'd9,1,1,0, 0,1,4'b1100,0,32'h00008001);
        tbl[5]  = mk(1,0,3'd2,32'h3002,0,0,5'd10,1,0,0, 1,0,0,0,0);
        tbl[6]  = mk(0,1,3'd1,32'h3001,32'h1234,0,5'd11,1,0,0, 1,0,0,0,0);
        tbl[7]  = mk(1,0,3'd3,32'h0000,0,0,5'd12,1,0,0, 1,0,0,0,0);
        tbl[8]  = mk(1,1,3'd2,32'h0010,0,0,5'd13,1,0,0, 1,0,0,0,0);
        tbl[9]  = mk(0,1,3'd4,32'h0020,0,0,5'd14,1,0,0, 1,0,0,0,0);
        tbl[10] = mk(0,1,3'd2,32'h0040,32'hDEADBEEF,0,5'd15,1,0,0, 0,0,4'b1111,32'hDEADBEEF,0);
        tbl[11] = mk(1,0,3'd2,32'h3000,0,32'h12345678,5'd16,0,3,1, 0,0,4'b1111,0,32'h12345678);
        tbl[12] = mk(0,0,3'd0,32'h1234,0,0,5'd7,1,0,0, 0,1,0,0,32'h1234);

        // Reset state
        #2;
        chk("rst in_ready", 32'(in_ready), 32'd0);
        chk("rst dmem_req", 32'(dmem_req), 32'd0);
        chk("rst wb_valid", 32'(wb_valid), 32'd0);
        chk("rst wb_data", wb_data, 32'd0);
        chk("rst dmem_addr", dmem_addr, 32'd0);
        chk("rst dmem_be", 32'(dmem_be), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 13; i++) run(tbl[i], $sformatf("vec%0d", i));

        // Back-to-back non-memory ops
        for (int i = 0; i < 3; i++) begin
            v = mk(0,0,3'd0,32'h11 * (i + 1),0,0,5'(i + 1),1,0,0, 0,1,0,0,0);
            chk($sformatf("b2b%0d in_ready", i), 32'(in_ready), 32'd1);
            drive(v);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d wb_valid", i), 32'(wb_valid), 32'd1);
            chk($sformatf("b2b%0d wb_data", i), wb_data, 32'h11 * (i + 1));
            chk($sformatf("b2b%0d wb_rd", i), 32'(wb_rd), 32'(i + 1));
        end
        idle_inputs();
        @(posedge clk); #1;
        chk("b2b wb_pulse", 32'(wb_valid), 32'd0);

        // Reset while waiting for grant drops the request immediately
        v = mk(0,1,3'd2,32'h80,32'h55,0,5'd3,1,0,0, 0,0,4'b1111,32'h55,0);
        drive(v);
        @(posedge clk); #1;
        idle_inputs();
        chk("rstreq req_before", 32'(dmem_req), 32'd1);
        rst_n = 1'b0; #1;
        chk("rstreq req_drop", 32'(dmem_req), 32'd0);
        chk("rstreq in_ready", 32'(in_ready), 32'd0);
        #2 rst_n = 1'b1;
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        chk("rstreq wb_valid", 32'(wb_valid), 32'd0);
        chk("rstreq ready", 32'(in_ready), 32'd1);

        // Reset while waiting for load data; late rvalid must be ignored
        v = mk(1,0,3'd2,32'h100,0,0,5'd4,1,0,0, 0,1,4'b1111,0,0);
        drive(v);
        @(posedge clk); #1;
        idle_inputs();
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        dmem_gnt = 1'b0;
        rst_n = 1'b0; #1;
        chk("rstresp req", 32'(dmem_req), 32'd0);
        chk("rstresp wb_valid", 32'(wb_valid), 32'd0);
        chk("rstresp in_ready", 32'(in_ready), 32'd0);
        dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("rstresp wb_valid2", 32'(wb_valid), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        dmem_rvalid = 1'b0;
        chk("rstresp wb_valid3", 32'(wb_valid), 32'd0);
        chk("rstresp req3", 32'(dmem_req), 32'd0);
        chk("rstresp wb_data", wb_data, 32'd0);
        run(mk(1,0,3'd2,32'h0,0,32'hCAFEF00D,5'd20,1,0,1, 0,1,4'b1111,0,32'hCAFEF00D), "post_rst_lw");

        // Random transactions against the model
        for (int i = 0; i < 300; i++) begin
            v.ld = 1'b0; v.st = 1'b0;
            if ($urandom_range(0, 3) != 0) begin
                if ($urandom_range(0, 19) == 0) begin
                    v.ld = 1'b1; v.st = 1'b1;
                end else if ($urandom_range(0, 1) == 0) v.ld = 1'b1;
                else v.st = 1'b1;
            end
            v.f3 = 3'($urandom);
            v.addr = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (v.f3[1:0] == 2'd1) v.addr[0] = 1'b0;
                if (v.f3[1:0] == 2'd2) v.addr[1:0] = 2'b00;
            end
            v.sdata = $urandom; v.rdata = $urandom;
            v.rd = 5'($urandom); v.rw = 1'($urandom);
            v.gw = $urandom_range(0, 3); v.rvw = $urandom_range(0, 3);
            run(model(v), $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/r200_mem.md
# r200_mem

Memory-access stage of the r200 pipeline, directly downstream of the execute stage. Takes the execute-stage ALU result plus the instruction's load/store controls, and drives a single-port data-memory request/grant/response interface. Loads are byte/halfword-aligned and sign- or zero-extended before being handed to writeback; non-memory results are registered through unchanged. The stage stalls execute through a ready signal while a memory access is outstanding.

## Interface
- No parameters; all widths are fixed (RV32).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  execute result valid this cycle
- in_ready  out  1  stage accepts input; `in_valid & in_ready` = accepted
- in_alu_res  in  32  ALU result; this is the byte address for loads and stores
- in_store_data  in  32  rs2 value used for stores
- in_func3  in  3  instr[14:12], selecting memory width and sign handling
- in_load, in_store  in  1 each  instruction is a load or a store
- in_rd  in  5  destination register
- in_reg_write  in  1  instruction writes rd
- dmem_req  out  1  memory request
- dmem_gnt  in  1  request accepted this cycle
- dmem_addr  out  32  word address, {in_alu_res[31:2], 2'b00}
- dmem_we  out  1  1 = write
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rvalid  in  1  load data valid
- dmem_rdata  in  32  load data (whole word)
- wb_valid  out  1  one-cycle pulse per retired instruction
- wb_rd  out  5  destination register
- wb_data  out  32  result
- wb_we  out  1  register-file write enable
- wb_fault  out  1  misaligned access or illegal memory func3

## Operation
- State machine has three states: IDLE, REQ, RESP. `in_ready = rst_n & (state == IDLE)`.
- Acceptance latches every `in_*` field.
- **Non-memory instruction** (`in_load = in_store = 0`): state stays IDLE. Next cycle: wb_valid=1, wb_data=alu_res, wb_we=reg_write, wb_fault=0.
- **Fault check** applies to memory ops and is evaluated at acceptance. A fault is any of:
  - func3 ∉ {000, 001, 010, 100, 101}, or func3[2]=1 on a store;
  - halfword access with addr[0]=1;
  - word access with addr[1:0]≠0;
  - in_load and in_store both 1.
- On a fault: no dmem_req is issued. Next cycle: wb_valid=1, wb_fault=1, wb_we=0.
- **Valid memory op**: IDLE→REQ. In REQ, dmem_req=1 and addr/we/be/wdata are held stable until dmem_gnt.
- **Store**:
  - Byte: be = 4'b0001 << addr[1:0], wdata = {4{data[7:0]}}.
  - Half: be = addr[1] ? 1100 : 0011, wdata = {2{data[15:0]}}.
  - Word: be = 1111, wdata = data.
  - On gnt: REQ→IDLE. Next cycle: wb_valid=1, wb_we=0.
- **Load**: dmem_we=0, be as for a store of the same width. On gnt: REQ→RESP. In RESP, wait for dmem_rvalid. On rvalid:
  - Select the lane by addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw passes the word.
  - Register the result into wb_data with wb_we=reg_write. RESP→IDLE.
- dmem_rvalid is ignored outside RESP. dmem_gnt is ignored outside REQ.
- wb_* fields hold their last value when wb_valid=0.

## Timing
- Reset (asynchronous, immediate):
  - state=IDLE;
  - dmem_req, dmem_we, wb_valid, wb_we, wb_fault = 0;
  - dmem_addr, dmem_be, dmem_wdata, wb_data, wb_rd = 0;
  - in_ready=0 while rst_n is low.
- Reset mid-transaction abandons the access. dmem_req drops in the same instant; a late rvalid after reset is ignored.
- Latency from acceptance:
  - non-memory and fault cases: 1 cycle to wb_valid;
  - store: 1 + gnt wait + 1;
  - load: 1 + gnt wait + rvalid wait + 1.
- Throughput: non-memory instructions 1/cycle. Store with zero-wait gnt: accept at t0, req at t1, wb and next accept at t2.
- dmem_req is registered, never combinational from in_valid. rvalid is never expected in the gnt cycle.
- Writeback never backpressures.

## Test plan
- Back-to-back non-memory ops: alu_res 0x11, 0x22, 0x33 on consecutive cycles with rd 1/2/3 -> wb_valid for 3 consecutive cycles, wb_data 0x11/0x22/0x33, in_ready constantly 1.
- sb to address 0x1003 with data 0x000000A5, gnt delayed 2 cycles -> dmem_addr=0x1000, be=1000, wdata=0xA5A5A5A5, held stable for 3 cycles; wb_valid with wb_we=0 one cycle after gnt.
- lb from 0x2002 with rdata=0x00800000 -> wb_data=0xFFFFFF80. lbu from the same address -> 0x00000080. lh from 0x2002 with rdata 0x80010000 -> 0xFFFF8001.
- lw from 0x3002 and sh to 0x3001 -> no dmem_req; wb_fault=1 and wb_we=0 one cycle after acceptance. A memory op with func3=011 -> wb_fault=1.
- rst_n asserted in RESP, then rvalid pulse -> dmem_req=0 and wb_valid=0 throughout; after release, in_ready=1 and the next lw to 0x0 completes normally.
